// File: rtl/stn_fb_arb.sv
// Frame-buffer arbiter: serialises STN-detector writes and display reads onto one 8-bit single-port RAM.
// Optional macro FB_ARB_RDPRI_EN: reads win contention in IDLE (default build: writes win).
module stn_fb_arb #(
  parameter int                ADDR_W  = 13,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] RAM_TOP = 13'h17bf
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  output logic              o_wr_ack,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_req,
  output logic              o_rd_ack,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_err_oor
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_go_wr;
  logic                w_go_rd;
  logic                w_wr_oor;
  logic                w_rd_oor;
  logic                w_acc_oor;

  logic                r_wr_ack;
  logic                r_rd_ack;
  logic                r_ram_cs;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_acc_oor;
  logic                r_err_oor;
  logic                r_rdp_vld;
  logic                r_rdp_oor;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  assign w_wr_oor = (i_wr_addr > RAM_TOP);
  assign w_rd_oor = (i_rd_addr > RAM_TOP);

  // Next-state and grant decode; the losing requester simply stays pending
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_go_wr     = 1'b0;
    w_go_rd     = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef FB_ARB_RDPRI_EN
        if (i_rd_req) begin
          w_go_rd     = 1'b1;
          w_state_nxt = ST_RD;
        end else if (i_wr_req) begin
          w_go_wr     = 1'b1;
          w_state_nxt = ST_WR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`else
        if (i_wr_req) begin
          w_go_wr     = 1'b1;
          w_state_nxt = ST_WR;
        end else if (i_rd_req) begin
          w_go_rd     = 1'b1;
          w_state_nxt = ST_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_WR:   w_state_nxt = ST_IDLE;
      ST_RD:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Range check of whichever request is being granted this cycle
  always_comb begin
    w_acc_oor = 1'b0;
    if (w_go_wr) begin
      w_acc_oor = w_wr_oor;
    end else if (w_go_rd) begin
      w_acc_oor = w_rd_oor;
    end else begin
      w_acc_oor = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack and RAM strobes, registered one cycle after the grant; address/data hold between accesses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wdata <= {DATA_W{1'b0}};
      r_acc_oor   <= 1'b0;
    end else begin
      r_wr_ack  <= w_go_wr;
      r_rd_ack  <= w_go_rd;
      r_ram_cs  <= (w_go_wr | w_go_rd) & ~w_acc_oor;
      r_ram_we  <= w_go_wr;
      r_acc_oor <= w_acc_oor;
      if (w_go_wr) begin
        r_ram_addr  <= i_wr_addr;
        r_ram_wdata <= i_wr_data;
      end else if (w_go_rd) begin
        r_ram_addr  <= i_rd_addr;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err_oor <= 1'b0;
    end else if ((w_go_wr | w_go_rd) & w_acc_oor) begin
      r_err_oor <= 1'b1;
    end
  end

  // Read return: RAM data arrives the cycle after the strobe, out-of-range reads return zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdp_vld  <= 1'b0;
      r_rdp_oor  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
    end else begin
      r_rdp_vld  <= (r_state == ST_RD);
      r_rdp_oor  <= r_acc_oor;
      r_rd_valid <= r_rdp_vld;
      if (r_rdp_vld) begin
        r_rd_data <= r_rdp_oor ? {DATA_W{1'b0}} : i_ram_rdata;
      end
    end
  end

  assign o_wr_ack    = r_wr_ack;
  assign o_rd_ack    = r_rd_ack;
  assign o_ram_cs    = r_ram_cs;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_err_oor   = r_err_oor;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_stn_fb_arb.sv
// Self-checking bench for stn_fb_arb: RAM model plus a reference memory image and error flag.
// Contention expectations follow FB_ARB_RDPRI_EN when it is defined.
module tb_stn_fb_arb;
  localparam logic [12:0] RAM_TOP = 13'h17bf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic        wr_ack, rd_ack, rd_valid;
  logic [12:0] wr_addr, rd_addr, ram_addr;
  logic [7:0]  wr_data, rd_data, ram_wdata, ram_rdata;
  logic        ram_cs, ram_we, err_oor;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem     [0:8191];
  logic [7:0]  exp_mem [0:8191];
  logic        exp_err;
  logic [12:0] written_q [$];

  always #5 clk = ~clk;

  stn_fb_arb dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .o_wr_ack(wr_ack), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_req(rd_req), .o_rd_ack(rd_ack), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_err_oor(err_oor)
  );

  // Single-port synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_rd(input logic [12:0] a);
    return (a > RAM_TOP) ? 8'h00 : exp_mem[a];
  endfunction

  // Issue one write and report the ack latency and the RAM strobe seen in the ack cycle
  task automatic drv_write(input logic [12:0] a, input logic [7:0] d, output int lat,
                           output logic cs, output logic we, output logic [12:0] oa,
                           output logic [7:0] od, output logic err);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    lat = 99; cs = 1'b0; we = 1'b0; oa = 13'h0000; od = 8'h00; err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (wr_ack) begin
        lat = k; cs = ram_cs; we = ram_we; oa = ram_addr; od = ram_wdata; err = err_oor;
        break;
      end
    end
    wr_req = 1'b0;
    if (a > RAM_TOP) exp_err = 1'b1;
    else begin exp_mem[a] = d; written_q.push_back(a); end
    tick();
  endtask

  // Issue one read; vgap counts cycles from the ack cycle to the rd_valid cycle
  task automatic drv_read(input logic [12:0] a, output int lat, output int vgap,
                          output logic [7:0] data, output logic cs, output logic we);
    rd_req = 1'b1; rd_addr = a;
    lat = 99; vgap = 99; data = 8'hxx; cs = 1'b0; we = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (rd_ack) begin lat = k; cs = ram_cs; we = ram_we; break; end
    end
    rd_req = 1'b0;
    if (a > RAM_TOP) exp_err = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (rd_valid) begin vgap = j; data = rd_data; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = 13'h0000; rd_addr = 13'h0000; wr_data = 8'h00;
    tick(); tick(); tick();
    n_cmp++; if ({wr_ack, rd_ack, rd_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_acks: got %b expected 000", {wr_ack, rd_ack, rd_valid}); end
    n_cmp++; if ({ram_cs, ram_we, err_oor} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b expected 000", {ram_cs, ram_we, err_oor}); end
    n_cmp++; if ({ram_addr, ram_wdata, rd_data} !== 29'd0) begin n_bad++; $display("FAIL reset_data: got addr %h wdata %h rdata %h expected 0", ram_addr, ram_wdata, rd_data); end
    rst = 1'b0; exp_err = 1'b0;
    tick();
  endtask

  task automatic test_single_write;
    int lat; logic cs, we, err; logic [12:0] oa; logic [7:0] od;
    drv_write(13'h0000, 8'hA5, lat, cs, we, oa, od, err);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sw_lat: got %0d expected 1", lat); end
    n_cmp++; if ({cs, we} !== 2'b11) begin n_bad++; $display("FAIL sw_strobe: got cs/we %b expected 11", {cs, we}); end
    n_cmp++; if (oa !== 13'h0000 || od !== 8'hA5) begin n_bad++; $display("FAIL sw_addr_data: got %h/%h expected 0000/a5", oa, od); end
    n_cmp++; if ({wr_ack, ram_cs, ram_we} !== 3'b000) begin n_bad++; $display("FAIL sw_idle: got ack/cs/we %b expected 000", {wr_ack, ram_cs, ram_we}); end
  endtask

  task automatic test_write_read;
    int lat, vgap; logic cs, we, err; logic [12:0] oa; logic [7:0] od, data;
    drv_write(13'h0500, 8'h3C, lat, cs, we, oa, od, err);
    drv_read(13'h0500, lat, vgap, data, cs, we);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_rd_acklat: got %0d expected 1", lat); end
    n_cmp++; if ({cs, we} !== 2'b10) begin n_bad++; $display("FAIL wr_rd_strobe: got cs/we %b expected 10", {cs, we}); end
    n_cmp++; if (vgap !== 2) begin n_bad++; $display("FAIL wr_rd_vgap: got %0d expected 2", vgap); end
    n_cmp++; if (data !== 8'h3C) begin n_bad++; $display("FAIL wr_rd_data: got %h expected 3c", data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'h3C) begin n_bad++; $display("FAIL wr_rd_hold: got valid %b data %h expected 0/3c", rd_valid, rd_data); end
  endtask

  task automatic test_contention;
    int wt, rt, vt, nw, nr; logic [7:0] vd, d;
    int exp_wt, exp_rt;
`ifdef FB_ARB_RDPRI_EN
    exp_rt = 1; exp_wt = 3;
`else
    exp_wt = 1; exp_rt = 3;
`endif
    d = 8'($urandom_range(1, 255));
    wt = 0; rt = 0; vt = 0; nw = 0; nr = 0; vd = 8'h00;
    wr_req = 1'b1; wr_addr = 13'h0123; wr_data = d;
    rd_req = 1'b1; rd_addr = 13'h0500;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (wr_ack) begin nw++; if (wt == 0) wt = k; wr_req = 1'b0; end
      if (rd_ack) begin nr++; if (rt == 0) rt = k; rd_req = 1'b0; end
      if (rd_valid && vt == 0) begin vt = k; vd = rd_data; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    exp_mem[13'h0123] = d; written_q.push_back(13'h0123);
    n_cmp++; if (wt !== exp_wt) begin n_bad++; $display("FAIL cont_wr_time: got %0d expected %0d", wt, exp_wt); end
    n_cmp++; if (rt !== exp_rt) begin n_bad++; $display("FAIL cont_rd_time: got %0d expected %0d", rt, exp_rt); end
    n_cmp++; if (nw !== 1 || nr !== 1) begin n_bad++; $display("FAIL cont_ack_count: got wr %0d rd %0d expected 1/1", nw, nr); end
    n_cmp++; if (vt !== exp_rt + 2 || vd !== exp_mem[13'h0500]) begin n_bad++; $display("FAIL cont_rd_valid: got t %0d data %h expected %0d/%h", vt, vd, exp_rt + 2, exp_mem[13'h0500]); end
  endtask

  task automatic test_back_to_back;
    int gap, vgap, t; logic [7:0] d, vd; logic [12:0] a;
    for (int p = 0; p < 3; p++) begin
      a = 13'($urandom_range(0, 32'h17bf)); d = 8'($urandom);
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      t = 0;
      for (int k = 1; k <= 8 && t == 0; k++) begin tick(); if (wr_ack) t = k; end
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = a;
      exp_mem[a] = d; written_q.push_back(a);
      gap = 99; vgap = 99; vd = 8'h00;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (rd_ack && gap == 99) begin gap = k; rd_req = 1'b0; end
        if (rd_valid && vgap == 99) begin vgap = k; vd = rd_data; end
      end
      n_cmp++; if (t !== 1 || gap !== 2) begin n_bad++; $display("FAIL b2b_timing: got wr %0d rd gap %0d expected 1/2", t, gap); end
      n_cmp++; if (vgap !== 4 || vd !== exp_rd(a)) begin n_bad++; $display("FAIL b2b_data: got t %0d data %h expected 4/%h", vgap, vd, exp_rd(a)); end
    end
  endtask

  task automatic test_oor;
    int lat, vgap; logic cs, we, err; logic [12:0] oa; logic [7:0] od, data;
    n_cmp++; if (err_oor !== 1'b0) begin n_bad++; $display("FAIL oor_pre: got %b expected 0", err_oor); end
    drv_write(13'h17c0, 8'h77, lat, cs, we, oa, od, err);
    n_cmp++; if (lat !== 1 || cs !== 1'b0) begin n_bad++; $display("FAIL oor_wr: got lat %0d cs %b expected 1/0", lat, cs); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err_set: got %b expected 1", err); end
    tick(); tick();
    n_cmp++; if (err_oor !== 1'b1) begin n_bad++; $display("FAIL oor_err_sticky: got %b expected 1", err_oor); end
    drv_read(13'h1800, lat, vgap, data, cs, we);
    n_cmp++; if (lat !== 1 || cs !== 1'b0) begin n_bad++; $display("FAIL oor_rd: got lat %0d cs %b expected 1/0", lat, cs); end
    n_cmp++; if (vgap !== 2 || data !== 8'h00) begin n_bad++; $display("FAIL oor_rd_data: got t %0d data %h expected 2/00", vgap, data); end
  endtask

  task automatic test_reset_in_rd;
    int t, nv; logic cs, we, err; logic [12:0] oa; logic [7:0] od;
    drv_write(13'h0040, 8'h5A, t, cs, we, oa, od, err);
    rd_req = 1'b1; rd_addr = 13'h0040; t = 0;
    for (int k = 1; k <= 8 && t == 0; k++) begin tick(); if (rd_ack) t = k; end
    n_cmp++; if (t !== 1) begin n_bad++; $display("FAIL rst_rd_ack: got %0d expected 1", t); end
    rst = 1'b1; rd_req = 1'b0;
    tick();
    n_cmp++; if ({wr_ack, rd_ack, rd_valid, ram_cs, ram_we, err_oor} !== 6'b000000) begin n_bad++; $display("FAIL rst_rd_flags: got %b expected 000000", {wr_ack, rd_ack, rd_valid, ram_cs, ram_we, err_oor}); end
    n_cmp++; if ({ram_addr, ram_wdata, rd_data} !== 29'd0) begin n_bad++; $display("FAIL rst_rd_data: got %h %h %h expected 0", ram_addr, ram_wdata, rd_data); end
    rst = 1'b0; exp_err = 1'b0; nv = 0;
    for (int k = 0; k < 4; k++) begin tick(); if (rd_valid) nv++; end
    n_cmp++; if (nv !== 0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd_suppress: got %0d valids data %h expected 0/00", nv, rd_data); end
  endtask

  task automatic test_boundary;
    int lat, vgap; logic cs, we, err; logic [12:0] oa; logic [7:0] od, data, d;
    d = 8'($urandom_range(1, 255));
    drv_write(13'h17bf, d, lat, cs, we, oa, od, err);
    n_cmp++; if ({cs, we} !== 2'b11 || oa !== 13'h17bf || od !== d) begin n_bad++; $display("FAIL bnd_wr: got cs/we %b addr %h data %h expected 11/17bf/%h", {cs, we}, oa, od, d); end
    n_cmp++; if (err_oor !== 1'b0) begin n_bad++; $display("FAIL bnd_err: got %b expected 0", err_oor); end
    drv_read(13'h17bf, lat, vgap, data, cs, we);
    n_cmp++; if (cs !== 1'b1 || data !== d) begin n_bad++; $display("FAIL bnd_rd: got cs %b data %h expected 1/%h", cs, data, d); end
  endtask

  task automatic test_random;
    int lat, vgap; logic cs, we, err; logic [12:0] oa, a; logic [7:0] od, data, d;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 13'($urandom_range(32'h17c0, 32'h1fff));
      else if ($urandom_range(0, 1) == 1 && written_q.size() > 0) a = written_q[$urandom_range(0, written_q.size() - 1)];
      else a = 13'($urandom_range(0, 32'h17bf));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        drv_write(a, d, lat, cs, we, oa, od, err);
        n_cmp++; if (lat !== 1 || cs !== (a <= RAM_TOP) || (cs && (oa !== a || od !== d))) begin n_bad++; $display("FAIL rnd_wr: addr %h got lat %0d cs %b %h/%h expected 1/%b %h/%h", a, lat, cs, oa, od, a <= RAM_TOP, a, d); end
      end else begin
        drv_read(a, lat, vgap, data, cs, we);
        n_cmp++; if (lat !== 1 || vgap !== 2 || data !== exp_rd(a)) begin n_bad++; $display("FAIL rnd_rd: addr %h got lat %0d gap %0d data %h expected 1/2/%h", a, lat, vgap, data, exp_rd(a)); end
      end
      n_cmp++; if (err_oor !== exp_err) begin n_bad++; $display("FAIL rnd_err: got %b expected %b", err_oor, exp_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    ram_rdata = 8'h00;
    exp_err = 1'b0;
    test_reset();
    test_single_write();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_oor();
    test_reset_in_rd();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
